pc_unit_ras: RTL and testbench



---
 rtl/pc_unit_ras_if.sv | 31 +++
 rtl/pc_unit_ras.sv | 104 ++++++++++
 tb/tb_pc_unit_ras.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_ras_if.sv
// Fetch-side bundle of the program-counter unit: redirect/stall requests coming
// in from the later pipeline stages, and the PC / return-stack status going out.
interface pc_unit_ras_if #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              freeze;
   logic              Branch_taken;
   logic [ADDR_W-1:0] BranchAddr;
   logic              call_push;
   logic [ADDR_W-1:0] link_addr;
   logic              ret_pop;
   logic              exc_req;
   logic [ADDR_W-1:0] pc_out;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_err;

   // Pipeline side: issues redirects and stalls, observes the PC.
   modport master (
      output freeze, Branch_taken, BranchAddr, call_push, link_addr, ret_pop, exc_req,
      input  pc_out, ras_count, ras_err
   );

   // PC unit side.
   modport slave (
      input  freeze, Branch_taken, BranchAddr, call_push, link_addr, ret_pop, exc_req,
      output pc_out, ras_count, ras_err
   );
endinterface

// File: rtl/pc_unit_ras.sv
// Program-counter unit for the fetch stage with prioritised redirects
// (exception > branch > predicted return > stall > increment) and a circular
// return-address stack that overwrites its oldest entry when full.
module pc_unit_ras #(
   parameter int                ADDR_W       = 32,
   parameter int                INSTR_BYTES  = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'd8),
   parameter int                RAS_DEPTH    = 4
) (
   input  logic         clk,
   input  logic         rst,
   pc_unit_ras_if.slave bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Clearing the low bits keeps every PC and every stacked return address
   // aligned to the instruction size.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));
   localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] PC_RST     = RESET_VECTOR & ALIGN_MASK;
   localparam logic [ADDR_W-1:0] PC_EXC     = EXC_VECTOR & ALIGN_MASK;
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

   function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
      return addr & ALIGN_MASK;
   endfunction

   logic [ADDR_W-1:0] pc_r,  pc_nxt_s;
   logic [PTR_W-1:0]  top_r, top_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic              err_r, err_nxt_s;
   logic              push_s;
   logic [ADDR_W-1:0] push_data_s;
   logic [ADDR_W-1:0] ras_r [RAS_DEPTH];

   // Next-state selection: first matching redirect source wins, stall only blocks the increment.
   always_comb begin
      pc_nxt_s    = pc_r;
      top_nxt_s   = top_r;
      cnt_nxt_s   = cnt_r;
      err_nxt_s   = 1'b0;
      push_s      = 1'b0;
      push_data_s = align(bus.link_addr);
      if (bus.exc_req) begin
         pc_nxt_s  = PC_EXC;
         top_nxt_s = '0;
         cnt_nxt_s = '0;
      end else if (bus.Branch_taken) begin
         pc_nxt_s = align(bus.BranchAddr);
         if (bus.call_push) begin
            // Pointer wraps, so a push when full lands on the oldest entry.
            push_s    = 1'b1;
            top_nxt_s = top_r + PTR_W'(1);
            if (cnt_r == CNT_FULL) begin
               cnt_nxt_s = cnt_r;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end else begin
            push_s = 1'b0;
         end
      end else if (bus.ret_pop && (cnt_r != '0)) begin
         pc_nxt_s  = ras_r[top_r];
         top_nxt_s = top_r - PTR_W'(1);
         cnt_nxt_s = cnt_r - CNT_W'(1);
      end else begin
         // An unserviceable return falls through to stall/increment and is flagged.
         err_nxt_s = bus.ret_pop;
         if (bus.freeze) begin
            pc_nxt_s = pc_r;
         end else begin
            pc_nxt_s = pc_r + PC_INC;
         end
      end
   end

   // PC, stack pointer, occupancy and error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r  <= PC_RST;
         top_r <= '0;
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         pc_r  <= pc_nxt_s;
         top_r <= top_nxt_s;
         cnt_r <= cnt_nxt_s;
         err_r <= err_nxt_s;
      end
   end

   // Stack storage: contents are meaningless until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         ras_r[top_nxt_s] <= push_data_s;
      end
   end

   assign bus.pc_out    = pc_r;
   assign bus.ras_count = cnt_r;
   assign bus.ras_err   = err_r;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed walk through the call/return, priority and
// overflow scenarios followed by random traffic, all scored against a stack
// model; a second small-width instance covers PC wrap-around.
module tb_pc_unit_ras;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pc_unit_ras_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();
   pc_unit_ras_if #(.ADDR_W(8),  .RAS_DEPTH(4)) bus8 ();

   pc_unit_ras dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   pc_unit_ras #(
      .ADDR_W(8), .INSTR_BYTES(2), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h08), .RAS_DEPTH(4)
   ) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   typedef struct {
      logic [31:0] pc;
      int          cnt;
      logic        err;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   string       cur_tag = "reset";

   // Reference model: the return stack is a plain list, newest at the back.
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endfunction

   task automatic model_reset();
      m_pc = 32'h0000_0000;
      m_ras.delete();
   endtask

   task automatic model_step(input bit exc, input bit br, input logic [31:0] ba, input bit call,
                             input logic [31:0] la, input bit ret, input bit frz);
      logic err;
      err = 1'b0;
      if (exc) begin
         m_pc = 32'd8;
         m_ras.delete();
      end else if (br) begin
         m_pc = {ba[31:2], 2'b00};
         if (call) begin
            m_ras.push_back({la[31:2], 2'b00});
            if (m_ras.size() > 4) void'(m_ras.pop_front());
         end
      end else if (ret && (m_ras.size() > 0)) begin
         m_pc = m_ras.pop_back();
      end else begin
         err = ret;
         if (!frz) m_pc = m_pc + 32'd4;
      end
      exp_q.push_back('{m_pc, m_ras.size(), err, cur_tag});
   endtask

   // Entered at a falling edge; applies one cycle of inputs and leaves at the next falling edge.
   task automatic drive(input bit exc, input bit br, input logic [31:0] ba, input bit call,
                        input logic [31:0] la, input bit ret, input bit frz);
      bus.exc_req      = exc;
      bus.Branch_taken = br;
      bus.BranchAddr   = ba;
      bus.call_push    = call;
      bus.link_addr    = la;
      bus.ret_pop      = ret;
      bus.freeze       = frz;
      model_step(exc, br, ba, call, la, ret, frz);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 10)) begin
         @(posedge clk);
         #3;
         n++;
      end
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: every updated output after a clock edge is compared with the oldest expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, "_pc"},  64'(bus.pc_out),    64'(mon_e.pc));
            check({mon_e.tag, "_cnt"}, 64'(bus.ras_count), 64'(mon_e.cnt));
            check({mon_e.tag, "_err"}, 64'(bus.ras_err),   64'(mon_e.err));
         end
      end
   end

   // Narrow instance: 0xFC after reset, then wraps through 0xFE to 0x00.
   initial begin
      bus8.exc_req      = 1'b0;
      bus8.Branch_taken = 1'b0;
      bus8.BranchAddr   = 8'h00;
      bus8.call_push    = 1'b0;
      bus8.link_addr    = 8'h00;
      bus8.ret_pop      = 1'b0;
      bus8.freeze       = 1'b0;
      @(negedge rst);
      #1;
      check("wrap_pc0", 64'(bus8.pc_out), 64'h00FC);
      @(posedge clk);
      #1;
      check("wrap_pc1", 64'(bus8.pc_out), 64'h00FE);
      @(posedge clk);
      #1;
      check("wrap_pc2", 64'(bus8.pc_out), 64'h0000);
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Main stimulus sequence.
   initial begin
      bus.exc_req      = 1'b0;
      bus.Branch_taken = 1'b0;
      bus.BranchAddr   = 32'h0;
      bus.call_push    = 1'b0;
      bus.link_addr    = 32'h0;
      bus.ret_pop      = 1'b0;
      bus.freeze       = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc",  64'(bus.pc_out),    64'd0);
      check("rst_cnt", 64'(bus.ras_count), 64'd0);
      check("rst_err", 64'(bus.ras_err),   64'd0);
      rst = 1'b0;
      model_reset();

      cur_tag = "incr";
      repeat (4) idle();
      cur_tag = "freeze";
      repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

      cur_tag = "prio_exc";
      drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
      cur_tag = "prio_br_frz";
      drive(1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0, 1'b1);

      cur_tag = "call";
      drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h44, 1'b0, 1'b0);
      cur_tag = "call_gap";
      repeat (2) idle();
      cur_tag = "ret";
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

      cur_tag = "ovf_push";
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 1'b1, 32'h300 + 32'(i * 16), 1'b1, 32'(i * 16), 1'b0, 1'b0);
      end
      cur_tag = "ovf_pop";
      repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      cur_tag = "after_err";
      idle();

      cur_tag = "pre_arst";
      drive(1'b0, 1'b1, 32'h400, 1'b1, 32'h1000, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h500, 1'b1, 32'h2000, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h80,  1'b1, 32'h3000, 1'b0, 1'b0);
      drain();
      check("pre_arst_pc",  64'(bus.pc_out),    64'h80);
      check("pre_arst_cnt", 64'(bus.ras_count), 64'd3);
      rst = 1'b1;
      #1;
      check("arst_pc",  64'(bus.pc_out),    64'd0);
      check("arst_cnt", 64'(bus.ras_count), 64'd0);
      check("arst_err", 64'(bus.ras_err),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      cur_tag = "rand";
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom(),
               $urandom_range(1) == 1, $urandom(), $urandom_range(2) == 0,
               $urandom_range(3) == 0);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
